pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter stage of a single-cycle MIPS core. Holds the
//               PC, decodes control-flow opcodes from the fetched word,
//               selects the next PC, detects self-loop halts, flags
//               misaligned register jumps and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [31:0]            Instruction,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   halted,
    output logic                   misaligned,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_FN_JR      = 6'h08;
    localparam logic [5:0] c_FN_JALR    = 6'h09;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   misaligned_q, misaligned_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_r_target;
    logic        w_is_jreg;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    assign w_opcode    = Instruction[31:26];
    assign w_funct     = Instruction[5:0];
    assign w_br_offset = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
    assign w_br_target = pc_plus4 + w_br_offset;
    assign w_j_target  = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    assign w_r_target  = {rs_data[31:2], 2'b00};
    assign w_is_jreg   = (w_opcode == c_OP_SPECIAL) &&
                         ((w_funct == c_FN_JR) || (w_funct == c_FN_JALR));

    // Decode the fetched word into a taken flag and its control-flow target
    always_comb begin
        w_taken  = 1'b0;
        w_target = pc_plus4;
        case (w_opcode)
            c_OP_BEQ: begin
                w_taken  = (rs_data == rt_data);
                w_target = w_br_target;
            end
            c_OP_BNE: begin
                w_taken  = (rs_data != rt_data);
                w_target = w_br_target;
            end
            c_OP_J, c_OP_JAL: begin
                w_taken  = 1'b1;
                w_target = w_j_target;
            end
            c_OP_SPECIAL: begin
                if (w_is_jreg) begin
                    w_taken  = 1'b1;
                    w_target = w_r_target;
                end
            end
            default: begin
                w_taken  = 1'b0;
                w_target = pc_plus4;
            end
        endcase
        w_next_pc = w_taken ? w_target : pc_plus4;
    end

    // Next-state logic: advance in RUN unless stalled, freeze in HALT
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        count_d      = count_q;
        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    pc_d    = w_next_pc;
                    count_d = count_q + COUNT_WIDTH'(1);
                    if (w_is_jreg && (rs_data[1:0] != 2'b00)) begin
                        misaligned_d = 1'b1;
                    end
                    // A taken transfer back onto itself can never make progress
                    if (w_taken && (w_target == pc_q)) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State registers; reset overrides stall and halt
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    assign pc            = pc_q;
    assign halted        = (state_q == S_HALT);
    assign misaligned    = misaligned_q;
    assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] Instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;
    logic [31:0] retired_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .COUNT_WIDTH (32)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .Instruction   (Instruction),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .misaligned    (misaligned),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one instruction and let one rising edge consume it
    task automatic step(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        Instruction = ins;
        rs_data     = rs;
        rt_data     = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        Instruction = 32'h0;
        rs_data     = 32'h0;
        rt_data     = 32'h0;
        @(posedge clk);
        #1;
        check("rst_pc",       pc,                   32'h0);
        check("rst_pc_plus4", pc_plus4,             32'h4);
        check("rst_halted",   {31'b0, halted},      32'h0);
        check("rst_misalign", {31'b0, misaligned},  32'h0);
        check("rst_count",    retired_count,        32'h0);
        reset = 1'b0;

        // Sequential words
        step(32'h2004_0005, 32'h0, 32'h0);
        check("seq1_pc", pc, 32'h4);
        step(32'h0000_1026, 32'h0, 32'h0);
        check("seq2_pc", pc, 32'h8);
        step(32'h0000_0000, 32'h0, 32'h0);
        check("seq3_pc",    pc,            32'hC);
        check("seq3_count", retired_count, 32'd3);

        // Self-loop beq $0,$0,-1 at 0xC halts
        step(32'h1000_FFFF, 32'h0, 32'h0);
        check("halt_pc",     pc,              32'hC);
        check("halt_flag",   {31'b0, halted}, 32'h1);
        check("halt_count",  retired_count,   32'd4);
        for (int i = 0; i < 10; i++) step(32'h0800_0040, 32'h0, 32'h0);
        check("halt_pc_frozen",    pc,              32'hC);
        check("halt_count_frozen", retired_count,   32'd4);
        check("halt_still",        {31'b0, halted}, 32'h1);
        reset = 1'b1;
        step(32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        check("halt_rst_pc",     pc,              32'h0);
        check("halt_rst_halted", {31'b0, halted}, 32'h0);
        check("halt_rst_count",  retired_count,   32'h0);

        // jal 4 from pc 0x8
        step(32'h0, 32'h0, 32'h0);
        step(32'h0, 32'h0, 32'h0);
        check("pre_jal_pc", pc, 32'h8);
        Instruction = 32'h0C00_0004;
        #1;
        check("jal_pc_plus4", pc_plus4, 32'hC);
        step(32'h0C00_0004, 32'h0, 32'h0);
        check("jal_pc",    pc,            32'h10);
        check("jal_count", retired_count, 32'd3);

        // Branches from 0x20
        step(32'h0800_0008, 32'h0, 32'h0);
        check("j20_pc", pc, 32'h20);
        step(32'h1000_0002, 32'h0, 32'h0);
        check("beq_taken_pc", pc, 32'h2C);
        step(32'h0800_0008, 32'h0, 32'h0);
        step(32'h1000_0002, 32'h0, 32'h1);
        check("beq_not_taken_pc", pc, 32'h24);
        step(32'h0800_0008, 32'h0, 32'h0);
        step(32'h1400_0002, 32'h0, 32'h1);
        check("bne_taken_pc", pc, 32'h2C);
        step(32'h0800_0008, 32'h0, 32'h0);
        step(32'h1400_0002, 32'h5, 32'h5);
        check("bne_not_taken_pc", pc, 32'h24);

        // Register jumps from 0x28
        step(32'h0800_000A, 32'h0, 32'h0);
        check("j28_pc", pc, 32'h28);
        step(32'h0000_0008, 32'h3C, 32'h0);
        check("jr_pc",       pc,                  32'h3C);
        check("jr_misalign", {31'b0, misaligned}, 32'h0);
        step(32'h0800_000A, 32'h0, 32'h0);
        step(32'h0000_0008, 32'h3E, 32'h0);
        check("jr_mis_pc",   pc,                  32'h3C);
        check("jr_mis_flag", {31'b0, misaligned}, 32'h1);
        step(32'h0000_0000, 32'h0, 32'h0);
        check("mis_sticky_pc",   pc,                  32'h40);
        check("mis_sticky_flag", {31'b0, misaligned}, 32'h1);
        check("pre_stall_count", retired_count,       32'd16);

        // Stall during a j
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step(32'h0800_0040, 32'h0, 32'h0);
        check("stall_pc",    pc,            32'h40);
        check("stall_count", retired_count, 32'd16);
        stall = 1'b0;
        step(32'h0800_0040, 32'h0, 32'h0);
        check("unstall_pc",    pc,            32'h100);
        check("unstall_count", retired_count, 32'd17);

        // PC wrap at the top of the address space
        step(32'h0000_0008, 32'hFFFF_FFFC, 32'h0);
        check("top_pc",       pc,       32'hFFFF_FFFC);
        check("top_pc_plus4", pc_plus4, 32'h0);
        step(32'h2004_0005, 32'h0, 32'h0);
        check("wrap_pc",    pc,            32'h0);
        check("wrap_count", retired_count, 32'd19);

        // Reset asserted while stalled
        stall = 1'b1;
        reset = 1'b1;
        step(32'h0800_0040, 32'h0, 32'h0);
        check("rst_stall_pc",    pc,                  32'h0);
        check("rst_stall_count", retired_count,       32'h0);
        check("rst_stall_mis",   {31'b0, misaligned}, 32'h0);
        reset = 1'b0;
        stall = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
